// File: rtl/inst_mem_loader.sv
// Instruction-fetch responder backed by a word RAM, with a byte-serial boot loader
// that holds the core in reset while loading. Optional checksum: INST_MEM_CHECKSUM_EN.
module inst_mem_loader #(
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ce,
   input  logic [31:0]       addr,
   output logic [31:0]       inst,
   input  logic              ld_start,
   input  logic              ld_valid,
   input  logic [7:0]        ld_byte,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              cpu_hold,
   output logic [ADDR_W:0]   word_cnt,
   output logic              ovf,
   output logic [31:0]       chk
);

   localparam int unsigned    DEPTH    = 2 ** ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

   typedef enum logic [1:0] {
      IDLE,
      LOAD,
      DONE,
      RUN
   } state_t;

   state_t state_q, state_d;

   logic [31:0]       mem [DEPTH];
   logic [ADDR_W:0]   word_cnt_q;
   logic [1:0]        byte_cnt_q;
   logic [31:0]       asm_q;
   logic              ovf_q;

   logic              accept;
   logic              word_wr;
   logic              full;
   logic              mem_we;
   logic [31:0]       byte_word;
   logic [31:0]       new_word;

   logic [ADDR_W-1:0] rd_idx;
   logic              in_range;
   logic              unused_addr_bits;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= IDLE;
      else      state_q <= state_d;
   end

   // ld_start restarts a load from every state and takes priority over a same-cycle byte
   always_comb begin
      state_d  = state_q;
      ld_ready = 1'b0;
      cpu_hold = 1'b1;
      case (state_q)
         IDLE: begin
            if (ld_start) state_d = LOAD;
         end
         LOAD: begin
            ld_ready = 1'b1;
            if (ld_start)                 state_d = LOAD;
            else if (ld_valid && ld_last) state_d = DONE;
         end
         DONE: begin
            if (ld_start) state_d = LOAD;
            else          state_d = RUN;
         end
         RUN: begin
            cpu_hold = 1'b0;
            if (ld_start) state_d = LOAD;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept  = ld_valid & ld_ready & ~ld_start;
      word_wr = accept & ((byte_cnt_q == 2'd3) | ld_last);
      full    = (word_cnt_q == FULL_CNT);
      mem_we  = word_wr & ~full;
      case (byte_cnt_q)
         2'd0:    byte_word = {ld_byte, 24'h0};
         2'd1:    byte_word = {8'h0, ld_byte, 16'h0};
         2'd2:    byte_word = {16'h0, ld_byte, 8'h0};
         default: byte_word = {24'h0, ld_byte};
      endcase
      new_word = asm_q | byte_word;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         ovf_q      <= 1'b0;
      end else if (ld_start) begin
         word_cnt_q <= '0;
         byte_cnt_q <= '0;
         asm_q      <= '0;
         ovf_q      <= 1'b0;
      end else if (accept) begin
         if (word_wr) begin
            // unused low bytes of a short final word come out as zero
            byte_cnt_q <= '0;
            asm_q      <= '0;
            if (full) ovf_q      <= 1'b1;
            else      word_cnt_q <= word_cnt_q + 1'b1;
         end else begin
            byte_cnt_q <= byte_cnt_q + 1'b1;
            asm_q      <= new_word;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) mem[word_cnt_q[ADDR_W-1:0]] <= new_word;
   end

`ifdef INST_MEM_CHECKSUM_EN
   logic [31:0] chk_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)        chk_q <= '0;
      else if (ld_start) chk_q <= '0;
      else if (mem_we) chk_q <= chk_q ^ new_word;
   end

   assign chk = chk_q;
`else
   assign chk = '0;
`endif

   assign word_cnt = word_cnt_q;
   assign ovf      = ovf_q;

   assign rd_idx           = addr[ADDR_W+1:2];
   assign in_range         = (addr[31:ADDR_W+2] == '0);
   assign unused_addr_bits = ^addr[1:0];

   // writes only happen under cpu_hold, so the read path needs no bypass
   always_comb begin
      inst = '0;
      if (ce && !cpu_hold && in_range) inst = mem[rd_idx];
   end

endmodule

// File: tb/tb_inst_mem_loader.sv
// Directed bench for inst_mem_loader: a default-size instance and an ADDR_W=2 instance
// share the load port; expectations are hand-computed, checksum expectation follows INST_MEM_CHECKSUM_EN.
module tb_inst_mem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        ce;
   logic [31:0] addr;
   logic        ld_start;
   logic        ld_valid;
   logic [7:0]  ld_byte;
   logic        ld_last;

   logic [31:0] inst_a, chk_a;
   logic        ld_ready_a, cpu_hold_a, ovf_a;
   logic [10:0] word_cnt_a;

   logic [31:0] inst_b, chk_b;
   logic        ld_ready_b, cpu_hold_b, ovf_b;
   logic [2:0]  word_cnt_b;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   always #5 clk = ~clk;

   inst_mem_loader #(.ADDR_W(10)) dut_a (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_a),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
      .ld_ready(ld_ready_a), .cpu_hold(cpu_hold_a), .word_cnt(word_cnt_a),
      .ovf(ovf_a), .chk(chk_a)
   );

   inst_mem_loader #(.ADDR_W(2)) dut_b (
      .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst_b),
      .ld_start(ld_start), .ld_valid(ld_valid), .ld_byte(ld_byte), .ld_last(ld_last),
      .ld_ready(ld_ready_b), .cpu_hold(cpu_hold_b), .word_cnt(word_cnt_b),
      .ovf(ovf_b), .chk(chk_b)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s: got %08h expected %08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_load();
      ld_start = 1'b1;
      tick();
      ld_start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic last);
      ld_valid = 1'b1;
      ld_byte  = b;
      ld_last  = last;
      tick();
      ld_valid = 1'b0;
      ld_last  = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w, input logic last);
      send_byte(w[31:24], 1'b0);
      send_byte(w[23:16], 1'b0);
      send_byte(w[15:8],  1'b0);
      send_byte(w[7:0],   last);
   endtask

   logic [31:0] exp_chk;

   initial begin
      rst = 1'b0; ce = 1'b1; addr = '0;
      ld_start = 1'b0; ld_valid = 1'b0; ld_byte = '0; ld_last = 1'b0;
      tick(); tick();
      rst = 1'b1;
      tick();

      // reset release, no load
      check("rst_inst",     inst_a, 32'h0);
      check("rst_hold",     32'(cpu_hold_a), 32'h1);
      check("rst_ready",    32'(ld_ready_a), 32'h0);
      check("rst_word_cnt", 32'(word_cnt_a), 32'h0);
      check("rst_ovf",      32'(ovf_a), 32'h0);
      check("rst_chk",      chk_a, 32'h0);

      // two full words
      start_load();
      check("load_ready", 32'(ld_ready_a), 32'h1);
      send_word(32'h12345678, 1'b0);
      send_word(32'h9ABCDEF0, 1'b1);
      check("done_hold",     32'(cpu_hold_a), 32'h1);
      check("done_ready",    32'(ld_ready_a), 32'h0);
      check("two_word_cnt",  32'(word_cnt_a), 32'h2);
      tick();
      check("run_hold",  32'(cpu_hold_a), 32'h0);
      check("run_ready", 32'(ld_ready_a), 32'h0);
      addr = 32'h0; #1 check("fetch_0", inst_a, 32'h12345678);
      addr = 32'h4; #1 check("fetch_4", inst_a, 32'h9ABCDEF0);
      addr = 32'h7; #1 check("fetch_7", inst_a, 32'h9ABCDEF0);
      ce = 1'b0;    #1 check("fetch_ce0", inst_a, 32'h0);
      ce = 1'b1;
`ifdef INST_MEM_CHECKSUM_EN
      exp_chk = 32'h88888888;
`else
      exp_chk = 32'h0;
`endif
      check("chk_two_word", chk_a, exp_chk);

      // partial final word padded with zeros
      start_load();
      check("reload_word_cnt", 32'(word_cnt_a), 32'h0);
      send_byte(8'hAA, 1'b0);
      send_byte(8'hBB, 1'b1);
      check("partial_word_cnt", 32'(word_cnt_a), 32'h1);
      tick();
      addr = 32'h0;    #1 check("partial_fetch", inst_a, 32'hAABB0000);
      addr = 32'h4;    #1 check("partial_keep_1", inst_a, 32'h9ABCDEF0);
      addr = 32'h4000; #1 check("out_of_range", inst_a, 32'h0);

      // restart mid-load; the byte presented with ld_start is dropped
      start_load();
      send_byte(8'h11, 1'b0);
      send_byte(8'h22, 1'b0);
      ld_start = 1'b1; ld_valid = 1'b1; ld_byte = 8'hFF;
      tick();
      ld_start = 1'b0; ld_valid = 1'b0;
      check("restart_ready", 32'(ld_ready_a), 32'h1);
      send_word(32'h01020304, 1'b1);
      check("restart_word_cnt", 32'(word_cnt_a), 32'h1);
      tick();
      addr = 32'h0; #1 check("restart_fetch", inst_a, 32'h01020304);
`ifdef INST_MEM_CHECKSUM_EN
      exp_chk = 32'h01020304;
`else
      exp_chk = 32'h0;
`endif
      check("restart_chk", chk_a, exp_chk);

      // overflow on the 4-word instance, the large one takes all 5 words
      start_load();
      send_word(32'h11111111, 1'b0);
      send_word(32'h22222222, 1'b0);
      send_word(32'h33333333, 1'b0);
      send_word(32'h44444444, 1'b0);
      check("ovf_not_yet", 32'(ovf_b), 32'h0);
      send_word(32'h55555555, 1'b1);
      check("ovf_word_cnt_b", 32'(word_cnt_b), 32'h4);
      check("ovf_flag_b",     32'(ovf_b), 32'h1);
      check("ovf_word_cnt_a", 32'(word_cnt_a), 32'h5);
      check("ovf_flag_a",     32'(ovf_a), 32'h0);
      tick();
      addr = 32'h0;  #1 check("ovf_fetch0_b", inst_b, 32'h11111111);
      addr = 32'hC;  #1 check("ovf_fetch3_b", inst_b, 32'h44444444);
      addr = 32'h10; #1 check("ovf_range_b",  inst_b, 32'h0);
      check("ovf_fetch4_a", inst_a, 32'h55555555);
`ifdef INST_MEM_CHECKSUM_EN
      exp_chk = 32'h44444444;
`else
      exp_chk = 32'h0;
`endif
      check("ovf_chk_b", chk_b, exp_chk);
`ifdef INST_MEM_CHECKSUM_EN
      exp_chk = 32'h11111111;
`else
      exp_chk = 32'h0;
`endif
      check("ovf_chk_a", chk_a, exp_chk);

      // ld_start with nothing else resets ovf
      start_load();
      check("ovf_cleared", 32'(ovf_b), 32'h0);

      // asynchronous reset in the middle of a load
      send_word(32'hA1A2A3A4, 1'b0);
      send_byte(8'hA5, 1'b0);
      check("pre_rst_word_cnt", 32'(word_cnt_a), 32'h1);
      #2 rst = 1'b0;
      #1;
      check("async_ready",    32'(ld_ready_a), 32'h0);
      check("async_word_cnt", 32'(word_cnt_a), 32'h0);
      check("async_hold",     32'(cpu_hold_a), 32'h1);
      check("async_chk",      chk_a, 32'h0);
      tick();
      rst = 1'b1;
      tick();
      addr = 32'h0; #1 check("post_rst_inst", inst_a, 32'h0);
      check("post_rst_ready", 32'(ld_ready_a), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
